// File: rtl/gost_round_ctrl.sv
// gost_round_ctrl: round sequencer for the Magma (GOST R 34.12-2015) 64-bit
// block cipher. Drives an external single-round datapath through 32
// start/done handshakes, selects each round key from the 256-bit master key,
// feeds each round result back as the next round input and presents the
// half-swapped result with a one-cycle odone pulse.
//
// Optional feature: define GOST_DECRYPT_EN to add the idecrypt input
// (latched with istart) that switches the key schedule to decryption order.
//
// Handshake: oround_start is a one-cycle request; oround_block/oround_key
// are held stable from that cycle until iround_done is seen. iround_done is
// a one-cycle completion strobe and is only honoured while waiting on a
// round; at any other time it is ignored.
module gost_round_ctrl #(
    parameter int ROUNDS = 32
) (
    input  logic         iclk,
    input  logic         irst,
    input  logic         istart,
    input  logic [63:0]  iblock,
    input  logic [255:0] ikey,
`ifdef GOST_DECRYPT_EN
    input  logic         idecrypt,
`endif
    output logic [63:0]  oblock,
    output logic         odone,
    output logic         obusy,
    output logic         oround_start,
    output logic [63:0]  oround_block,
    output logic [31:0]  oround_key,
    input  logic [63:0]  iround_block,
    input  logic         iround_done
);

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [4:0]       cnt_q;
    logic [4:0]       cnt_d;
    logic [63:0]      block_q;
    logic [7:0][31:0] key_q;      // word 7 holds K1, word 0 holds K8
    logic [31:0]      rkey_q;
    logic [31:0]      rkey_d;
    logic [2:0]       slot_d;     // zero-based key number (K(slot+1))
    logic             desc_d;
    logic [63:0]      oblock_q;
    logic             done_q;
    logic             busy_q;
    logic             rstart_q;
`ifdef GOST_DECRYPT_EN
    logic             dec_q;
`endif

    // Key for the round that follows the current one: direction comes from
    // the top two counter bits, the key slot from the low three bits.
    always_comb begin
        cnt_d = cnt_q + 5'd1;
`ifdef GOST_DECRYPT_EN
        desc_d = dec_q ? (cnt_d[4:3] != 2'b00) : (cnt_d[4:3] == 2'b11);
`else
        desc_d = (cnt_d[4:3] == 2'b11);
`endif
        slot_d = desc_d ? ~cnt_d[2:0] : cnt_d[2:0];
        rkey_d = key_q[3'd7 - slot_d];
    end

    // Sequencer FSM; all handshake and result outputs are registered here.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            block_q  <= 64'd0;
            key_q    <= '0;
            rkey_q   <= 32'd0;
            oblock_q <= 64'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            rstart_q <= 1'b0;
`ifdef GOST_DECRYPT_EN
            dec_q    <= 1'b0;
`endif
        end else begin
            rstart_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (istart) begin
                        block_q  <= iblock;
                        key_q    <= ikey;
                        cnt_q    <= 5'd0;
                        // Round 0 uses K1 in both directions.
                        rkey_q   <= ikey[255:224];
`ifdef GOST_DECRYPT_EN
                        dec_q    <= idecrypt;
`endif
                        rstart_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (iround_done) begin
                        block_q <= iround_block;
                        if (cnt_q == LAST_ROUND) begin
                            // Undo the swap the datapath did in the last round.
                            oblock_q <= {iround_block[31:0], iround_block[63:32]};
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            cnt_q    <= cnt_d;
                            rkey_q   <= rkey_d;
                            rstart_q <= 1'b1;
                            state_q  <= RUN;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign oblock       = oblock_q;
    assign odone        = done_q;
    assign obusy        = busy_q;
    assign oround_start = rstart_q;
    assign oround_block = block_q;
    assign oround_key   = rkey_q;

endmodule
